// File: rtl/mini_alu_pkg.sv
// Shared definitions for the MiniAlu execute unit.
// Opcodes, FSM state encoding and a constant clog2 helper.
package mini_alu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LED = 4'd1;
    localparam logic [3:0] OP_BLE = 4'd2;
    localparam logic [3:0] OP_STO = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    // Never returns 0 so single-entry files still get a 1-bit address.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mini_alu_regfile.sv
// DEPTH x WIDTH register file: async clear, one write port,
// three combinational read ports.
module mini_alu_regfile
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/mini_alu_exec.sv
// MiniAlu execute unit: single-cycle ALU ops plus iterative multiplier.
// Define MINIALU_EARLY_MUL_EN to let MUL finish once the multiplier drains.
module mini_alu_exec
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int LED_W = 8,
    parameter int PC_W  = 8,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iValid,
    output logic             oReady,
    input  logic [3:0]       iOpcode,
    input  logic [AW-1:0]    iDest,
    input  logic [AW-1:0]    iSrc0,
    input  logic [AW-1:0]    iSrc1,
    input  logic [WIDTH-1:0] iImm,
    output logic             oBranchTaken,
    output logic [PC_W-1:0]  oBranchTarget,
    output logic [LED_W-1:0] oLed,
    output logic             oCarry,
    output logic             oIllegal,
    input  logic [AW-1:0]    iDbgAddr,
    output logic [WIDTH-1:0] oDbgData
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AW-1:0]    mdest_q, mdest_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [PC_W-1:0]  tgt_q, tgt_d;
    logic             carry_q, carry_d;
    logic             br_q, br_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic             mul_done;
    logic [WIDTH-1:0] rs0, rs1;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]   sum, diff;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    mini_alu_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk    (Clock),
        .rst_n  (Reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr0 (iSrc0),
        .raddr1 (iSrc1),
        .raddr2 (iDbgAddr),
        .rdata0 (rs0),
        .rdata1 (rs1),
        .rdata2 (oDbgData)
    );

    assign accept  = iValid & oReady;
    assign acc_nxt = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign sum     = {1'b0, rs1} + {1'b0, rs0};
    // Top bit of the widened difference is the borrow.
    assign diff    = {1'b0, rs1} - {1'b0, rs0};

`ifdef MINIALU_EARLY_MUL_EN
    assign mul_done = (cnt_q == LAST) || ((mplr_q >> 1) == '0);
`else
    assign mul_done = (cnt_q == LAST);
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && iOpcode == OP_MUL) state_d = MUL_RUN;
            end
            MUL_RUN: begin
                if (mul_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oReady = (state_q == IDLE);
    end

    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        mdest_d = mdest_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        tgt_d   = tgt_q;
        carry_d = carry_q;
        br_d    = 1'b0;
        ill_d   = 1'b0;
        we      = 1'b0;
        waddr   = iDest;
        wdata   = iImm;
        if (state_q == MUL_RUN) begin
            acc_d   = acc_nxt;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (mul_done) begin
                we    = 1'b1;
                waddr = mdest_q;
                wdata = acc_nxt;
            end
        end else if (accept) begin
            case (iOpcode)
                OP_NOP: ;
                OP_LED: led_d = rs1[LED_W-1:0];
                OP_BLE: begin
                    if (rs1 <= rs0) begin
                        br_d  = 1'b1;
                        tgt_d = iImm[PC_W-1:0];
                    end
                end
                OP_STO: we = 1'b1;
                OP_ADD: begin
                    we      = 1'b1;
                    wdata   = sum[WIDTH-1:0];
                    carry_d = sum[WIDTH];
                end
                OP_JMP: begin
                    br_d  = 1'b1;
                    tgt_d = iImm[PC_W-1:0];
                end
                OP_SUB: begin
                    we      = 1'b1;
                    wdata   = diff[WIDTH-1:0];
                    carry_d = diff[WIDTH];
                end
                OP_MUL: begin
                    mcand_d = rs1;
                    mplr_d  = rs0;
                    mdest_d = iDest;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
                default: ill_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            mdest_q <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            tgt_q   <= '0;
            carry_q <= 1'b0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            mdest_q <= mdest_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            tgt_q   <= tgt_d;
            carry_q <= carry_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
        end
    end

    assign oBranchTaken  = br_q;
    assign oBranchTarget = tgt_q;
    assign oLed          = led_q;
    assign oCarry        = carry_q;
    assign oIllegal      = ill_q;

endmodule
